seq_multiplier: RTL

//  Multi-cycle radix-2 shift-add multiplier for the 24-bit single-cycle CPU.

---
 rtl/mul_pkg.sv | 13 +
 rtl/mul_abs.sv | 13 +
 rtl/seq_multiplier.sv | 93 +++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared constants and FSM state type for the sequential shift-add multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 24;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_abs.sv
// Conditional two's-complement magnitude: negates a negative operand in signed mode.
module mul_abs #(
  parameter int WIDTH = 24
) (
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] mag
);

  // The most negative value maps to 2^(WIDTH-1), which is still representable unsigned.
  assign mag = (signed_mode && value[WIDTH-1]) ? (~value + 1'b1) : value;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: WIDTH iterations on operand magnitudes, then a sign fix-up.
// Handshake: Start is sampled only in IDLE; Done/MulWrite pulse for one cycle with a valid Product.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   OpA,
  input  logic [WIDTH-1:0]   OpB,
  output logic [2*WIDTH-1:0] Product,
  output logic               MulWrite,
  output logic               Busy,
  output logic               Done,
  output mul_state_t         dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mul_state_t       state;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH:0] acc;
  logic [CNT_W-1:0] count;
  logic             neg;
  logic [WIDTH:0]   sum;

  mul_abs #(.WIDTH(WIDTH)) u_abs_a (
    .signed_mode (Signed),
    .value       (OpA),
    .mag         (mag_a)
  );

  mul_abs #(.WIDTH(WIDTH)) u_abs_b (
    .signed_mode (Signed),
    .value       (OpB),
    .mag         (mag_b)
  );

  // Upper half plus carry; the multiplier occupies the lower half and drains out as it shifts.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};

  assign dbg_state = state;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      Product  <= '0;
      MulWrite <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      count    <= '0;
      neg      <= 1'b0;
    end else begin
      Done     <= 1'b0;
      MulWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            mcand <= mag_a;
            acc   <= {{(WIDTH+1){1'b0}}, mag_b};
            neg   <= Signed & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
            count <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (acc[0]) acc <= {1'b0, sum, acc[WIDTH-1:1]};
          else        acc <= {1'b0, acc[2*WIDTH:1]};
          count <= count + 1'b1;
          if (count == LAST_ITER) state <= SIGN;
        end
        SIGN: begin
          Product  <= neg ? (~acc[2*WIDTH-1:0] + 1'b1) : acc[2*WIDTH-1:0];
          Done     <= 1'b1;
          MulWrite <= 1'b1;
          Busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
